// File: rtl/inst_cache_refill_ctrl.sv
// Direct-mapped instruction cache lookup/refill controller.
// Owns the line valid bits and drives the external tag and data array ports.
module inst_cache_refill_ctrl #(
  parameter int TAG_W      = 7,
  parameter int INDEX_W    = 7,
  parameter int LINE_WORDS = 4,
  localparam int OFFSET_W  = $clog2(LINE_WORDS),
  localparam int ADDR_W    = TAG_W + INDEX_W + OFFSET_W + 2
) (
  input  logic                clk,
  input  logic                nReset,
  // Request handshake: ReqAddr is taken on a cycle where ReqValid && ReqReady;
  // the requester holds ReqValid/ReqAddr stable until then.
  input  logic                ReqValid,
  input  logic [ADDR_W-1:0]   ReqAddr,
  input  logic                Flush,
  output logic                ReqReady,
  output logic                HitValid,
  output logic                Enable,
  output logic [INDEX_W-1:0]  CacheIndexRead,
  input  logic [TAG_W-1:0]    TagCompare,
  output logic                WriteTag,
  output logic [INDEX_W-1:0]  CacheIndexWrite,
  output logic [TAG_W-1:0]    WriteAddressTag,
  output logic                MemReq,
  output logic [ADDR_W-1:0]   MemAddr,
  input  logic                MemValid,
  input  logic [31:0]         MemData,
  output logic                DataWrite,
  output logic [INDEX_W-1:0]  DataIndex,
  output logic [OFFSET_W-1:0] DataOffset,
  output logic [31:0]         DataWord,
  output logic [15:0]         MissCount,
  output logic [2:0]          DbgState
);

  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    TAGWR  = 3'd3,
    RETRY  = 3'd4
  } state_t;

  state_t                 state;
  logic [TAG_W-1:0]       tag_q;
  logic [INDEX_W-1:0]     idx_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic                   flush_pend;
  logic [OFFSET_W-1:0]    word_cnt;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_W-1:0]     req_idx;
  logic                   idle_ok;
  logic                   accept;
  logic                   hit;
  logic                   addr_unused;

  assign req_tag     = ReqAddr[ADDR_W-1 -: TAG_W];
  assign req_idx     = ReqAddr[OFFSET_W+2 +: INDEX_W];
  assign addr_unused = ^ReqAddr[OFFSET_W+1:0];

  // A pending flush blocks the request exactly like a live Flush does.
  assign idle_ok = nReset && (state == IDLE) && !Flush && !flush_pend;
  assign accept  = idle_ok && ReqValid;
  assign hit     = valid_q[idx_q] && (TagCompare == tag_q);

  assign ReqReady        = idle_ok;
  assign Enable          = accept || (state == RETRY);
  assign CacheIndexRead  = accept ? req_idx : ((state == RETRY) ? idx_q : '0);
  assign HitValid        = (state == LOOKUP) && hit;
  assign WriteTag        = (state == TAGWR);
  assign CacheIndexWrite = (state == TAGWR) ? idx_q : '0;
  assign WriteAddressTag = (state == TAGWR) ? tag_q : '0;
  assign MemReq          = (state == FILL);
  assign MemAddr         = (state == FILL) ? {tag_q, idx_q, {(OFFSET_W+2){1'b0}}} : '0;
  assign DbgState        = state;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      valid_q    <= '0;
      flush_pend <= 1'b0;
      word_cnt   <= '0;
      MissCount  <= '0;
      DataWrite  <= 1'b0;
      DataIndex  <= '0;
      DataOffset <= '0;
      DataWord   <= '0;
    end else begin
      DataWrite  <= 1'b0;
      DataIndex  <= '0;
      DataOffset <= '0;
      DataWord   <= '0;
      if (Flush && (state != IDLE)) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (Flush || flush_pend) begin
            valid_q    <= '0;
            flush_pend <= 1'b0;
          end else if (ReqValid) begin
            tag_q <= req_tag;
            idx_q <= req_idx;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            MissCount <= MissCount + 16'd1;
            word_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (MemValid) begin
            DataWrite  <= 1'b1;
            DataIndex  <= idx_q;
            DataOffset <= word_cnt;
            DataWord   <= MemData;
            word_cnt   <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) state <= TAGWR;
          end
        end
        TAGWR: begin
          valid_q[idx_q] <= 1'b1;
          state          <= RETRY;
        end
        RETRY: begin
          state <= LOOKUP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache_refill_ctrl.sv
// Directed bench for inst_cache_refill_ctrl with a behavioural tag memory
// answering Enable/WriteTag one cycle later, like the real tag array.
module tb_inst_cache_refill_ctrl;

  localparam int TAG_W    = 7;
  localparam int INDEX_W  = 7;
  localparam int OFFSET_W = 2;
  localparam int ADDR_W   = 18;

  logic                clk;
  logic                nReset;
  logic                ReqValid;
  logic [ADDR_W-1:0]   ReqAddr;
  logic                Flush;
  logic                ReqReady;
  logic                HitValid;
  logic                Enable;
  logic [INDEX_W-1:0]  CacheIndexRead;
  logic [TAG_W-1:0]    TagCompare;
  logic                WriteTag;
  logic [INDEX_W-1:0]  CacheIndexWrite;
  logic [TAG_W-1:0]    WriteAddressTag;
  logic                MemReq;
  logic [ADDR_W-1:0]   MemAddr;
  logic                MemValid;
  logic [31:0]         MemData;
  logic                DataWrite;
  logic [INDEX_W-1:0]  DataIndex;
  logic [OFFSET_W-1:0] DataOffset;
  logic [31:0]         DataWord;
  logic [15:0]         MissCount;
  logic [2:0]          DbgState;

  logic [TAG_W-1:0] tag_mem [128];
  int n_assert = 0;
  int n_fail   = 0;

  inst_cache_refill_ctrl dut (
    .clk(clk), .nReset(nReset), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
    .Flush(Flush), .ReqReady(ReqReady), .HitValid(HitValid), .Enable(Enable),
    .CacheIndexRead(CacheIndexRead), .TagCompare(TagCompare),
    .WriteTag(WriteTag), .CacheIndexWrite(CacheIndexWrite),
    .WriteAddressTag(WriteAddressTag), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemValid(MemValid), .MemData(MemData), .DataWrite(DataWrite),
    .DataIndex(DataIndex), .DataOffset(DataOffset), .DataWord(DataWord),
    .MissCount(MissCount), .DbgState(DbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tag memory: registered read, write on strobe
  always @(posedge clk) begin
    if (Enable) TagCompare <= tag_mem[CacheIndexRead];
    if (WriteTag) tag_mem[CacheIndexWrite] <= WriteAddressTag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Present a request in IDLE and step into LOOKUP.
  task automatic accept(input logic [ADDR_W-1:0] addr);
    logic [INDEX_W-1:0] idx;
    idx = addr[10:4];
    ReqValid = 1'b1;
    ReqAddr  = addr;
    #1;
    chk("req_ready", {31'b0, ReqReady}, 32'd1);
    chk("enable", {31'b0, Enable}, 32'd1);
    chk("cache_index_read", {25'b0, CacheIndexRead}, {25'b0, idx});
    tick();
    ReqValid = 1'b0;
    ReqAddr  = '0;
  endtask

  // Called in a missing LOOKUP cycle; streams a line and ends in the IDLE cycle after HitValid.
  task automatic refill(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx,
                        input int gap, input bit flush_pulse, input logic [15:0] exp_miss);
    logic [31:0] d;
    chk("lookup_miss", {31'b0, HitValid}, 32'd0);
    tick();
    chk("fill_mem_req", {31'b0, MemReq}, 32'd1);
    chk("fill_mem_addr", {14'b0, MemAddr}, {14'b0, tag, idx, 4'b0});
    chk("miss_count", {16'b0, MissCount}, {16'b0, exp_miss});
    Flush = flush_pulse;
    for (int w = 0; w < 4; w++) begin
      repeat (gap) begin
        MemValid = 1'b0;
        tick();
        Flush = 1'b0;
        chk("gap_data_write", {31'b0, DataWrite}, 32'd0);
        chk("gap_mem_req", {31'b0, MemReq}, 32'd1);
      end
      d = 32'hC0DE_0000 + (32'(tag) << 12) + (32'(idx) << 4) + 32'(w);
      MemValid = 1'b1;
      MemData  = d;
      tick();
      Flush = 1'b0;
      chk("data_write", {31'b0, DataWrite}, 32'd1);
      chk("data_index", {25'b0, DataIndex}, {25'b0, idx});
      chk("data_offset", {30'b0, DataOffset}, 32'(w));
      chk("data_word", DataWord, d);
      chk("mem_req_hold", {31'b0, MemReq}, (w < 3) ? 32'd1 : 32'd0);
    end
    MemValid = 1'b0;
    chk("write_tag", {31'b0, WriteTag}, 32'd1);
    chk("cache_index_write", {25'b0, CacheIndexWrite}, {25'b0, idx});
    chk("write_address_tag", {25'b0, WriteAddressTag}, {25'b0, tag});
    tick();
    chk("retry_enable", {31'b0, Enable}, 32'd1);
    chk("retry_index", {25'b0, CacheIndexRead}, {25'b0, idx});
    chk("retry_write_tag", {31'b0, WriteTag}, 32'd0);
    chk("retry_hit_valid", {31'b0, HitValid}, 32'd0);
    tick();
    chk("refill_hit_valid", {31'b0, HitValid}, 32'd1);
    tick();
    chk("idle_hit_valid", {31'b0, HitValid}, 32'd0);
    chk("idle_req_ready", {31'b0, ReqReady}, {31'b0, ~flush_pulse});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) tag_mem[i] = '0;
    TagCompare = '0;
    nReset   = 1'b0;
    ReqValid = 1'b0;
    ReqAddr  = '0;
    Flush    = 1'b0;
    MemValid = 1'b0;
    MemData  = '0;

    // 1: reset state, first miss and full refill of 0x00104
    tick();
    tick();
    chk("rst_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("rst_miss_count", {16'b0, MissCount}, 32'd0);
    chk("rst_mem_req", {31'b0, MemReq}, 32'd0);
    chk("rst_state", {29'b0, DbgState}, 32'd0);
    nReset = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, ReqReady}, 32'd1);
    accept(18'h00104);
    refill(7'd0, 7'h10, 0, 1'b0, 16'd1);

    // 2: resident line hits one cycle after accept
    accept(18'h00104);
    chk("hit_valid", {31'b0, HitValid}, 32'd1);
    chk("hit_mem_req", {31'b0, MemReq}, 32'd0);
    tick();
    chk("hit_pulse_len", {31'b0, HitValid}, 32'd0);
    chk("hit_miss_count", {16'b0, MissCount}, 32'd1);

    // 3: conflict misses on index 0x10
    accept(18'h00904);
    refill(7'd1, 7'h10, 0, 1'b0, 16'd2);
    accept(18'h00104);
    refill(7'd0, 7'h10, 0, 1'b0, 16'd3);

    // 4: Flush beats ReqValid; flush during a fill is applied afterwards
    Flush    = 1'b1;
    ReqValid = 1'b1;
    ReqAddr  = 18'h00104;
    #1;
    chk("flush_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("flush_enable", {31'b0, Enable}, 32'd0);
    tick();
    Flush = 1'b0;
    accept(18'h00104);
    refill(7'd0, 7'h10, 0, 1'b1, 16'd4);
    tick();

    // 5: flushed line misses again; memory words with 3-cycle gaps
    accept(18'h00104);
    refill(7'd0, 7'h10, 3, 1'b0, 16'd5);
    MemValid = 1'b1;
    tick();
    MemValid = 1'b0;
    chk("idle_memvalid_ignored", {31'b0, DataWrite}, 32'd0);
    chk("idle_mem_req", {31'b0, MemReq}, 32'd0);

    // 6: reset in the middle of a fill, then refill from scratch
    accept(18'h0105C);
    chk("abort_lookup_miss", {31'b0, HitValid}, 32'd0);
    tick();
    chk("abort_miss_count", {16'b0, MissCount}, 32'd6);
    MemValid = 1'b1;
    MemData  = 32'h1111_0000;
    tick();
    MemData  = 32'h1111_0001;
    tick();
    chk("abort_second_word", {30'b0, DataOffset}, 32'd1);
    nReset   = 1'b0;
    MemValid = 1'b0;
    ReqValid = 1'b1;
    ReqAddr  = 18'h0105C;
    #1;
    chk("abort_data_write", {31'b0, DataWrite}, 32'd0);
    chk("abort_mem_req", {31'b0, MemReq}, 32'd0);
    chk("abort_mem_addr", {14'b0, MemAddr}, 32'd0);
    chk("abort_write_tag", {31'b0, WriteTag}, 32'd0);
    chk("abort_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("abort_enable", {31'b0, Enable}, 32'd0);
    chk("abort_index_read", {25'b0, CacheIndexRead}, 32'd0);
    chk("abort_miss_cleared", {16'b0, MissCount}, 32'd0);
    chk("abort_state", {29'b0, DbgState}, 32'd0);
    tick();
    tick();
    chk("abort_no_tag_write", {31'b0, WriteTag}, 32'd0);
    ReqValid = 1'b0;
    nReset   = 1'b1;
    accept(18'h0105C);
    refill(7'd2, 7'h05, 0, 1'b0, 16'd1);
    accept(18'h0105C);
    chk("final_hit", {31'b0, HitValid}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
